// File: rtl/cache_pkg.sv
// Shared definitions for the data cache, its miss engine and Data_Memory.
// Holds the default line/address widths, the line offset width, the miss
// engine state encoding and a line-alignment helper for the default width.
package cache_pkg;

  localparam int CACHE_ADDR_W  = 32;
  localparam int CACHE_LINE_W  = 256;
  localparam int LINE_OFFSET_W = 5;   // 32-byte lines

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_WB_GAP,
    ST_FILL,
    ST_DONE,
    ST_ERR
  } miss_state_e;

  // Clear the byte-offset bits of a default-width address.
  function automatic logic [CACHE_ADDR_W-1:0] line_align(input logic [CACHE_ADDR_W-1:0] a);
    return {a[CACHE_ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_miss_engine_if.sv
// Line memory bus between the miss engine (master) and Data_Memory (slave).
//   mem_data_i   : read data from memory
//   mem_ack_i    : single-cycle completion pulse
//   mem_data_o   : write data to memory
//   mem_addr_o   : line-aligned address
//   mem_enable_o : request valid
//   mem_write_o  : 1 = write, 0 = read
interface dcache_miss_engine_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport master (
    input  mem_data_i, mem_ack_i,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport slave (
    output mem_data_i, mem_ack_i,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_miss_engine_timer.sv
// Memory wait timer: counts cycles of an outstanding transfer.
//   clk_i, rst_i : clock, async active-low reset
//   clr          : hold count at zero (outside a transfer)
//   en           : count this cycle (transfer active, no ack)
//   expired      : count has reached TIMEOUT-1
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  // One spare bit so the count never wraps at TIMEOUT.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/dcache_miss_engine.sv
// Data cache miss engine: optional write-back of a dirty victim line followed
// by a refill of the missing line over the 256-bit line memory bus.
//   clk_i, rst_i : clock, async active-low reset
//   req_i        : miss request (sampled in IDLE only)
//   wb_i         : victim dirty, write back first
//   wb_addr_i    : victim line address
//   wb_data_i    : victim line data
//   fill_addr_i  : missing line address
//   busy_o       : request in progress
//   done_o       : one-cycle completion pulse (also on timeout)
//   error_o      : sticky timeout flag, cleared by the next accepted request
//   fill_data_o  : last refilled line
//   mem          : memory bus (master side)
module dcache_miss_engine
  import cache_pkg::*;
#(
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int LINE_W  = CACHE_LINE_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wb_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LINE_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [LINE_W-1:0] fill_data_o,
  dcache_miss_engine_if.master mem
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

  miss_state_e       state, state_nxt;
  logic [ADDR_W-1:0] wb_addr_q, fill_addr_q;
  logic [LINE_W-1:0] wb_data_q;
  logic              accept, xfer, expired;

  assign accept = (state == ST_IDLE) && req_i;
  assign xfer   = (state == ST_WB) || (state == ST_FILL);

  // Timer is held at zero outside a transfer, so it restarts on every
  // entry to WB or FILL (the WB_GAP cycle separates the two).
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (!xfer),
    .en      (xfer && !mem.mem_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
    end else if (accept) begin
      wb_addr_q   <= wb_addr_i;
      wb_data_q   <= wb_data_i;
      fill_addr_q <= fill_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      error_o     <= 1'b0;
      fill_data_o <= '0;
    end else begin
      if (accept)                   error_o <= 1'b0;
      else if (state_nxt == ST_ERR) error_o <= 1'b1;
      if ((state == ST_FILL) && mem.mem_ack_i) fill_data_o <= mem.mem_data_i;
    end
  end

  // Ack is tested before expiry so an ack on the last allowed cycle succeeds.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_i) state_nxt = wb_i ? ST_WB : ST_FILL;
      ST_WB:     if (mem.mem_ack_i) state_nxt = ST_WB_GAP;
                 else if (expired)  state_nxt = ST_ERR;
      ST_WB_GAP: state_nxt = ST_FILL;
      ST_FILL:   if (mem.mem_ack_i) state_nxt = ST_DONE;
                 else if (expired)  state_nxt = ST_ERR;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from state, so an async reset drops the
  // request in the same timestep.
  always_comb begin
    mem.mem_enable_o = xfer;
    mem.mem_write_o  = (state == ST_WB);
    mem.mem_addr_o   = '0;
    mem.mem_data_o   = '0;
    if (state == ST_WB) begin
      mem.mem_addr_o = wb_addr_q & LINE_MASK;
      mem.mem_data_o = wb_data_q;
    end else if (state == ST_FILL) begin
      mem.mem_addr_o = fill_addr_q & LINE_MASK;
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE) || (state == ST_ERR);

endmodule

// File: tb/tb_dcache_miss_engine.sv
// Bench for dcache_miss_engine: a latency-programmable memory model drives the
// bus; expected per-cycle behaviour comes from cycle arithmetic on latency.
module tb_dcache_miss_engine;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0, wb_i = 1'b0;
  logic [AW-1:0] wb_addr_i = '0, fill_addr_i = '0;
  logic [LW-1:0] wb_data_i = '0;
  logic          busy_o, done_o, error_o;
  logic [LW-1:0] fill_data_o;

  dcache_miss_engine_if #(.ADDR_W(AW), .LINE_W(LW)) mif();

  dcache_miss_engine #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .wb_i        (wb_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .fill_addr_i (fill_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .fill_data_o (fill_data_o),
    .mem         (mif)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LW-1:0] init_line(input int i);
    if (i == 16) return {2{128'h0123456789abcdeffedcba9876543210}};
    if (i == 2)  return {16{16'hecfa}};
    return {8{32'h5a5a0000 | 32'(i)}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory model: ack arrives mem_lat cycles after enable rises (0 = never).
  logic [LW-1:0] mem [64];
  logic [LW-1:0] ref_mem [64];
  logic          mem_boot = 1'b1;
  int            mem_lat = 0;
  int            mcnt = 0;
  logic          ack_q = 1'b0;
  logic          spur = 1'b0;

  assign mif.mem_ack_i  = ack_q | spur;
  assign mif.mem_data_i = (mif.mem_enable_o && !mif.mem_write_o) ? mem[mif.mem_addr_o[10:5]] : '0;

  always @(posedge clk_i) begin
    if (mem_boot) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_line(i);
      mcnt  <= 0;
      ack_q <= 1'b0;
    end else begin
      if (ack_q && mif.mem_enable_o && mif.mem_write_o) mem[mif.mem_addr_o[10:5]] <= mif.mem_data_o;
      if (!mif.mem_enable_o || ack_q) begin
        mcnt  <= 0;
        ack_q <= 1'b0;
      end else begin
        mcnt  <= mcnt + 1;
        ack_q <= (mem_lat != 0) && (mcnt + 1 == mem_lat);
      end
    end
  end

  int            nvec = 0;
  int            nerr = 0;
  logic [LW-1:0] exp_fill = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle. Cycle c counts from the first
  // cycle after the accepting edge.
  task automatic run_txn(input bit wb, input logic [AW-1:0] wa, input logic [LW-1:0] wd,
                         input logic [AW-1:0] fa, input int lat, input bit noisy);
    bit            ok, en, wr;
    int            done_c;
    logic [AW-1:0] ad;
    ok     = (lat >= 1) && (lat <= TO - 1);
    done_c = !ok ? TO + 1 : (wb ? 2 * lat + 4 : lat + 2);
    mem_lat = lat;
    req_i = 1'b1; wb_i = wb; wb_addr_i = wa; wb_data_i = wd; fill_addr_i = fa;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk_i);
      spur = 1'b0;
      if (!ok)            begin en = (c <= TO);      wr = wb;   ad = wb ? wa : fa; end
      else if (!wb)       begin en = (c <= lat + 1); wr = 1'b0; ad = fa; end
      else if (c <= lat + 1) begin en = 1'b1;        wr = 1'b1; ad = wa; end
      else begin en = (c >= lat + 3) && (c <= 2 * lat + 3); wr = 1'b0; ad = fa; end
      ad = ad & ~32'h1f;
      chk1("busy", busy_o, 1'b1);
      chk1("done", done_o, c == done_c);
      chk1("error", error_o, !ok && (c == done_c));
      chk1("mem_enable", mif.mem_enable_o, en);
      if (en) begin
        chk1("mem_write", mif.mem_write_o, wr);
        chka("mem_addr", mif.mem_addr_o, ad);
        chkl("mem_data", mif.mem_data_o, wr ? wd : '0);
      end
      if (noisy) begin
        req_i = (c < done_c) ? 1'($urandom) : 1'b0;
        wb_i = 1'($urandom); wb_addr_i = $urandom; fill_addr_i = $urandom; wb_data_i = rand_line();
        if ((wb && ok && c == lat + 2) || (c == done_c)) spur = 1'b1;
      end else begin
        req_i = (c < done_c);
      end
    end
    if (ok) begin
      if (wb) ref_mem[wa[10:5]] = wd;
      exp_fill = ref_mem[fa[10:5]];
    end
    chkl("fill_at_done", fill_data_o, exp_fill);
    @(negedge clk_i);
    spur = 1'b0;
    chk1("busy_after", busy_o, 1'b0);
    chk1("done_after", done_o, 1'b0);
    chk1("error_after", error_o, !ok);
    chk1("enable_after", mif.mem_enable_o, 1'b0);
    chkl("fill_after", fill_data_o, exp_fill);
    if (ok && wb) chkl("mem_wb_line", mem[wa[10:5]], wd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_line(i);
    #2 rst_i = 1'b0;
    #1;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_error", error_o, 1'b0);
    chk1("rst_enable", mif.mem_enable_o, 1'b0);
    chkl("rst_fill", fill_data_o, '0);
    @(negedge clk_i);
    mem_boot = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Clean read miss, then dirty miss.
    run_txn(1'b0, 32'h0, '0, 32'h0000_0204, 10, 1'b0);
    chkl("clean_fill", fill_data_o, {2{128'h0123456789abcdeffedcba9876543210}});
    run_txn(1'b1, 32'h0000_0420, {32{8'ha5}}, 32'h0000_0040, 10, 1'b0);
    chkl("dirty_mem33", mem[33], {32{8'ha5}});
    chkl("dirty_fill", fill_data_o, {16{16'hecfa}});

    // Timeouts on read and on write-back, then recovery clears error_o.
    run_txn(1'b0, 32'h0, '0, 32'h0000_0100, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0260, rand_line(), 32'h0000_0120, 0, 1'b0);
    run_txn(1'b0, 32'h0, '0, 32'h0000_0140, 3, 1'b0);

    // Ack on the last allowed cycle succeeds.
    run_txn(1'b0, 32'h0, '0, 32'h0000_0180, TO - 1, 1'b0);
    run_txn(1'b1, 32'h0000_01a0, rand_line(), 32'h0000_01c0, TO - 1, 1'b0);

    // Spurious ack while idle.
    spur = 1'b1;
    @(negedge clk_i);
    spur = 1'b0;
    chk1("idle_ack_busy", busy_o, 1'b0);
    chk1("idle_ack_done", done_o, 1'b0);
    chk1("idle_ack_enable", mif.mem_enable_o, 1'b0);

    // Noisy request/inputs during the transfer, acks in WB_GAP and DONE.
    run_txn(1'b1, 32'h0000_02e0, rand_line(), 32'h0000_0300, 5, 1'b1);
    run_txn(1'b0, 32'h0, '0, 32'h0000_0320, 4, 1'b1);

    // Reset five cycles into a write-back.
    mem_lat = 12;
    req_i = 1'b1; wb_i = 1'b1; wb_addr_i = 32'h0000_03e0; wb_data_i = rand_line(); fill_addr_i = 32'h60;
    repeat (5) @(negedge clk_i);
    chk1("pre_rst_enable", mif.mem_enable_o, 1'b1);
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    chk1("mid_rst_enable", mif.mem_enable_o, 1'b0);
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_done", done_o, 1'b0);
    chk1("mid_rst_error", error_o, 1'b0);
    chkl("mid_rst_fill", fill_data_o, '0);
    exp_fill = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chkl("rst_no_wb", mem[31], ref_mem[31]);
    run_txn(1'b0, 32'h0, '0, 32'h0000_0060, 6, 1'b0);

    // Randomized traffic over 64 lines.
    for (int k = 0; k < 30; k++) begin
      int r, lat;
      r = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(1, 6);
      run_txn(1'($urandom), $urandom_range(0, 2047), rand_line(), $urandom_range(0, 2047), lat, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
